// File: rtl/clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// clb_cfg_loader
//
// Configuration sequencer for the CLB tile array. A byte-wide configuration
// stream arrives over a valid/ready handshake; every two bytes form one tile's
// 13-bit config word:
//   byte0 = cfg[7:0]
//   byte1 = {3'b101, cfg[12:8]}   (top three bits are a format tag)
// Each assembled word is written to the tile config registers with a one-cycle
// strobe. The fabric is held in reset until every tile has been written, then
// released and done_o is raised. A bad tag aborts the load with err_o.
//
// Optional feature (macro CLB_CFG_CHECKSUM_EN): after the last tile write, one
// extra byte is accepted and must equal the XOR of all 2*NUM_CLBS data bytes,
// otherwise the load ends in the error state.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous, active-high reset
//   start_i        one-cycle pulse, begins a load (ignored while busy)
//   s_data_i       config byte stream
//   s_valid_i      stream byte valid
//   s_ready_o      loader accepts a byte this cycle
//   cfg_we_o       one-cycle write strobe to a tile config register
//   cfg_addr_o     tile index being written
//   cfg_data_o     config word for that tile
//   fabric_rst_no  active-low reset to the CLB fabric
//   busy_o         load in progress
//   done_o         all tiles configured (sticky until next start)
//   err_o          load aborted on format error (sticky until next start)
// -----------------------------------------------------------------------------
module clb_cfg_loader #(
  parameter int NUM_CLBS = 16,
  parameter int CFG_W    = 13,
  parameter int ADDR_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              cfg_we_o,
  output logic [ADDR_W-1:0] cfg_addr_o,
  output logic [CFG_W-1:0]  cfg_data_o,
  output logic              fabric_rst_no,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [2:0]        TAG       = 3'b101;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CLBS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_LO,
    LOAD_HI,
    WRITE,
    DONE,
    ERROR
`ifdef CLB_CFG_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_lo;
  logic [ADDR_W-1:0] r_addr;
  logic              w_xfer;
  logic              w_start;
`ifdef CLB_CFG_CHECKSUM_EN
  logic [7:0]        r_xsum;
`endif

  assign w_xfer  = s_valid_i & s_ready_o;
  assign w_start = start_i & (r_state inside {IDLE, DONE, ERROR});

  // Next-state logic. Every registered output is derived from w_next so that
  // it is valid in the first cycle of the corresponding state.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERROR: if (start_i) w_next = LOAD_LO;
      LOAD_LO:           if (w_xfer)  w_next = LOAD_HI;
      LOAD_HI: begin
        if (w_xfer) w_next = (s_data_i[7:5] == TAG) ? WRITE : ERROR;
      end
      WRITE: begin
        if (r_addr == LAST_ADDR) begin
`ifdef CLB_CFG_CHECKSUM_EN
          w_next = CHECK;
`else
          w_next = DONE;
`endif
        end else begin
          w_next = LOAD_LO;
        end
      end
`ifdef CLB_CFG_CHECKSUM_EN
      CHECK: if (w_xfer) w_next = (s_data_i == r_xsum) ? DONE : ERROR;
`endif
      default:           w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments only, so every register samples the
    // pre-edge values regardless of statement order.
    if (rst_i) begin
      r_state       <= IDLE;
      r_lo          <= '0;
      r_addr        <= '0;
      s_ready_o     <= 1'b0;
      cfg_we_o      <= 1'b0;
      cfg_addr_o    <= '0;
      cfg_data_o    <= '0;
      fabric_rst_no <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
`ifdef CLB_CFG_CHECKSUM_EN
      r_xsum        <= '0;
`endif
    end else begin
      r_state <= w_next;

`ifdef CLB_CFG_CHECKSUM_EN
      s_ready_o <= w_next inside {LOAD_LO, LOAD_HI, CHECK};
      busy_o    <= w_next inside {LOAD_LO, LOAD_HI, WRITE, CHECK};
`else
      s_ready_o <= w_next inside {LOAD_LO, LOAD_HI};
      busy_o    <= w_next inside {LOAD_LO, LOAD_HI, WRITE};
`endif
      cfg_we_o      <= (w_next == WRITE);
      done_o        <= (w_next == DONE);
      err_o         <= (w_next == ERROR);
      fabric_rst_no <= (w_next == DONE);

      if (r_state == LOAD_LO && w_xfer) r_lo <= s_data_i;

      // Word and address only move on entry to WRITE and hold otherwise.
      if (r_state == LOAD_HI && w_next == WRITE) begin
        cfg_data_o <= {s_data_i[4:0], r_lo};
        cfg_addr_o <= r_addr;
      end

      // Internal tile counter stops at the last tile; it never wraps.
      if (w_start) begin
        r_addr <= '0;
      end else if (r_state == WRITE && w_next == LOAD_LO) begin
        r_addr <= r_addr + ADDR_W'(1);
      end

`ifdef CLB_CFG_CHECKSUM_EN
      if (w_start) begin
        r_xsum <= '0;
      end else if (w_xfer && (r_state inside {LOAD_LO, LOAD_HI})) begin
        r_xsum <= r_xsum ^ s_data_i;
      end
`endif
    end
  end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// Self-checking bench for clb_cfg_loader (NUM_CLBS = 4).
// Directed table-driven load, back-pressure, bad tag, start while busy, reset
// mid-load, then randomized loads checked against a stream-level model.
// -----------------------------------------------------------------------------
module tb_clb_cfg_loader;

  localparam int NUM_CLBS = 4;
  localparam int CFG_W    = 13;
  localparam int ADDR_W   = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [7:0]        s_data_i;
  logic              s_valid_i;
  logic              s_ready_o;
  logic              cfg_we_o;
  logic [ADDR_W-1:0] cfg_addr_o;
  logic [CFG_W-1:0]  cfg_data_o;
  logic              fabric_rst_no;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  clb_cfg_loader #(
    .NUM_CLBS (NUM_CLBS),
    .CFG_W    (CFG_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .s_data_i      (s_data_i),
    .s_valid_i     (s_valid_i),
    .s_ready_o     (s_ready_o),
    .cfg_we_o      (cfg_we_o),
    .cfg_addr_o    (cfg_addr_o),
    .cfg_data_o    (cfg_data_o),
    .fabric_rst_no (fabric_rst_no),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0]       b0;
    logic [7:0]       b1;
    logic [CFG_W-1:0] exp_word;
  } tile_vec_t;

  tile_vec_t vecs[NUM_CLBS];

  // Stimulus stream and what the monitor saw.
  logic [7:0]        stream_q[$];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [CFG_W-1:0]  wr_data_q[$];
  int                wr_cyc_q[$];
  int                consumed;
  int                end_cyc;
  bit                saw_done;
  bit                saw_err;

  // Reference expectations derived from the stream alone.
  logic [CFG_W-1:0]  exp_data_q[$];
  bit                exp_ok;
  int                exp_consumed;
  logic [7:0]        exp_xsum;

  function automatic void build_expect();
    logic [7:0] b0, b1;
    exp_data_q.delete();
    exp_ok       = 1'b1;
    exp_consumed = 0;
    exp_xsum     = '0;
    for (int t = 0; t < NUM_CLBS; t++) begin
      b0 = stream_q[2*t];
      b1 = stream_q[2*t+1];
      exp_consumed += 2;
      exp_xsum ^= b0 ^ b1;
      if (b1[7:5] != 3'b101) begin
        exp_ok = 1'b0;
        return;
      end
      exp_data_q.push_back({b1[4:0], b0});
    end
`ifdef CLB_CFG_CHECKSUM_EN
    exp_consumed++;
    if (stream_q[2*NUM_CLBS] != exp_xsum) exp_ok = 1'b0;
`endif
  endfunction

  function automatic logic [7:0] stream_xor();
    logic [7:0] x = '0;
    for (int i = 0; i < 2*NUM_CLBS; i++) x ^= stream_q[i];
    return x;
  endfunction

  // Pulse start, then feed stream_q until done/err or the budget expires.
  // valid_pct < 0 toggles s_valid_i every cycle. glitch_cyc pulses start_i
  // once mid-load. cyc counts clock edges after the one that took start_i.
  task automatic run_load(input string tag, input int valid_pct, input int glitch_cyc, input int budget);
    bit v;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    consumed = 0;
    saw_done = 1'b0;
    saw_err  = 1'b0;
    end_cyc  = -1;
    @(negedge clk_i);
    start_i   = 1'b1;
    s_valid_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    check({tag, "_busy_after_start"}, {busy_o, done_o, err_o, fabric_rst_no}, 4'b1000);
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cfg_we_o) begin
        wr_addr_q.push_back(cfg_addr_o);
        wr_data_q.push_back(cfg_data_o);
        wr_cyc_q.push_back(cyc);
      end
      if (done_o || err_o) begin
        saw_done = done_o;
        saw_err  = err_o;
        end_cyc  = cyc;
        break;
      end
      start_i = (cyc == glitch_cyc);
      if (valid_pct < 0) v = (cyc % 2 == 0);
      else               v = (int'($urandom_range(99)) < valid_pct);
      s_valid_i = v && (consumed < stream_q.size());
      s_data_i  = s_valid_i ? stream_q[consumed] : 8'($urandom);
      if (s_valid_i && s_ready_o) consumed++;
      @(negedge clk_i);
    end
    start_i   = 1'b0;
    s_valid_i = 1'b0;
    check({tag, "_finished"}, end_cyc >= 0, 1);
  endtask

  task automatic compare_run(input string tag);
    int n;
    build_expect();
    check({tag, "_nwrites"}, wr_data_q.size(), exp_data_q.size());
    n = (wr_data_q.size() < exp_data_q.size()) ? wr_data_q.size() : exp_data_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], i);
      check($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_data_q[i]);
    end
    check({tag, "_done"},     saw_done, exp_ok);
    check({tag, "_err"},      saw_err, !exp_ok);
    check({tag, "_fab_rst"},  fabric_rst_no, exp_ok);
    check({tag, "_consumed"}, consumed, exp_consumed);
    check({tag, "_idle_flags"}, {busy_o, s_ready_o, cfg_we_o}, 3'b000);
  endtask

  task automatic load_table();
    stream_q.delete();
    for (int i = 0; i < NUM_CLBS; i++) begin
      stream_q.push_back(vecs[i].b0);
      stream_q.push_back(vecs[i].b1);
    end
`ifdef CLB_CFG_CHECKSUM_EN
    stream_q.push_back(stream_xor());
`endif
  endtask

  task automatic check_table_writes(input string tag, input bit check_timing);
    check({tag, "_tbl_nwrites"}, wr_data_q.size(), NUM_CLBS);
    for (int i = 0; i < NUM_CLBS && i < wr_data_q.size(); i++) begin
      check($sformatf("%s_tbl_addr%0d", tag, i), wr_addr_q[i], i);
      check($sformatf("%s_tbl_data%0d", tag, i), wr_data_q[i], vecs[i].exp_word);
      if (check_timing) check($sformatf("%s_tbl_wcyc%0d", tag, i), wr_cyc_q[i], 3*i + 2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit any_act;
    bit hit;
    int nwr;
    logic [7:0] b1;

    vecs[0] = '{8'h34, 8'hB2, 13'h1234};
    vecs[1] = '{8'hFF, 8'hBF, 13'h1FFF};
    vecs[2] = '{8'h00, 8'hA0, 13'h0000};
    vecs[3] = '{8'h5A, 8'hA8, 13'h085A};

    rst_i     = 1'b1;
    start_i   = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = '0;

    // Reset state.
    repeat (2) @(negedge clk_i);
    check("reset_outputs",
          {s_ready_o, cfg_we_o, cfg_addr_o, cfg_data_o, fabric_rst_no, busy_o, done_o, err_o}, '0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_after_reset", {s_ready_o, busy_o, done_o, err_o, fabric_rst_no}, 5'b0);

    // Full back-to-back load; 3 cycles per tile.
    load_table();
    run_load("full", 100, -1, 200);
    check_table_writes("full", 1'b1);
`ifdef CLB_CFG_CHECKSUM_EN
    check("full_done_cycle", end_cyc, 3*NUM_CLBS + 1);
`else
    check("full_done_cycle", end_cyc, 3*NUM_CLBS);
`endif
    compare_run("full");

    // DONE holds and accepts nothing.
    any_act = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = 8'hB5;
      @(negedge clk_i);
      if (cfg_we_o || s_ready_o || !done_o || !fabric_rst_no) any_act = 1'b1;
    end
    s_valid_i = 1'b0;
    check("done_sticky_quiet", any_act, 1'b0);

    // Back-pressure: valid toggling every cycle.
    run_load("bp", -1, -1, 200);
    check_table_writes("bp", 1'b0);
    compare_run("bp");

    // start_i pulse during LOAD_HI of tile 1 is ignored.
    run_load("glitch", 100, 4, 200);
    check_table_writes("glitch", 1'b1);
    compare_run("glitch");

    // Bad tag on tile 1, then recovery.
    stream_q[3] = 8'h62;
    run_load("badtag", 100, -1, 200);
    compare_run("badtag");
    check("badtag_one_write", wr_data_q.size(), 1);
    load_table();
    run_load("recover", 100, -1, 200);
    compare_run("recover");

`ifdef CLB_CFG_CHECKSUM_EN
    // Wrong checksum byte.
    stream_q[2*NUM_CLBS] = 8'h00;
    run_load("badsum", 100, -1, 200);
    compare_run("badsum");
    load_table();
`endif

    // Reset right after the 2nd write.
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i  = 1'b0;
    consumed = 0;
    nwr      = 0;
    hit      = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cfg_we_o) nwr++;
      if (nwr == 2) begin
        hit = 1'b1;
        break;
      end
      s_valid_i = 1'b1;
      s_data_i  = stream_q[consumed];
      if (s_ready_o) consumed++;
      @(negedge clk_i);
    end
    check("rst_mid_reached", hit, 1'b1);
    s_valid_i = 1'b0;
    rst_i     = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_mid_outputs",
          {s_ready_o, cfg_we_o, cfg_addr_o, cfg_data_o, fabric_rst_no, busy_o, done_o, err_o}, '0);
    any_act = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = 8'($urandom);
      @(negedge clk_i);
      if (cfg_we_o || s_ready_o || busy_o || done_o || fabric_rst_no) any_act = 1'b1;
    end
    s_valid_i = 1'b0;
    check("rst_mid_stays_idle", any_act, 1'b0);

    // Randomized loads against the stream-level model.
    for (int r = 0; r < 24; r++) begin
      stream_q.delete();
      for (int t = 0; t < NUM_CLBS; t++) begin
        b1 = 8'($urandom);
        if ($urandom_range(5) != 0) b1[7:5] = 3'b101;
        else if (b1[7:5] == 3'b101) b1[5] = 1'b0;
        stream_q.push_back(8'($urandom));
        stream_q.push_back(b1);
      end
`ifdef CLB_CFG_CHECKSUM_EN
      if ($urandom_range(3) != 0) stream_q.push_back(stream_xor());
      else                        stream_q.push_back(stream_xor() ^ 8'h01);
`endif
      run_load($sformatf("rnd%0d", r), int'($urandom_range(100, 30)), -1, 400);
      compare_run($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
